// File: rtl/pipe_arb.sv
// Round-robin arbiter that shares one stall-free pipe_ex pipeline among NREQ requesters.
// A {valid, id} tag travels alongside the pipe so each returning result is attributed.
module pipe_arb #(
  parameter int unsigned N    = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*N-1:0] req_a_i,
  input  logic [NREQ*N-1:0] req_b_i,
  input  logic [NREQ*N-1:0] req_c_i,
  input  logic [NREQ*N-1:0] req_d_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [N-1:0]      pa_o,
  output logic [N-1:0]      pb_o,
  output logic [N-1:0]      pc_o,
  output logic [N-1:0]      pd_o,
  input  logic [N-1:0]      pf_i,
  output logic              rsp_valid_o,
  output logic [IDW-1:0]    rsp_id_o,
  output logic [N-1:0]      rsp_data_o,
  output logic [2:0]        inflight_o,
  output logic [15:0]       issue_cnt_o
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [IDW-1:0] id_q [LAT];
  logic [2:0]     inflight_q, inflight_d;
  logic [15:0]    issue_cnt_q, issue_cnt_d;

  logic [IDW:0]   cand;
  logic           found;
  logic [IDW-1:0] win_id;
  logic           issue;

  // Rotating search: candidate index wraps back below NREQ, so no modulo operator needed.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req_i[cand[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = cand[IDW-1:0];
      end
    end
  end

  assign issue = found & en_i & rst_ni;

  always_comb begin
    gnt_o = '0;
    if (issue) begin
      gnt_o[win_id] = 1'b1;
    end
  end

  always_comb begin
    pa_o = '0;
    pb_o = '0;
    pc_o = '0;
    pd_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (issue && (win_id == IDW'(i))) begin
        pa_o = req_a_i[i*N +: N];
        pb_o = req_b_i[i*N +: N];
        pc_o = req_c_i[i*N +: N];
        pd_o = req_d_i[i*N +: N];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
    end
  end

  assign vld_d = {vld_q[LAT-2:0], issue};

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, rsp_valid_o})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign issue_cnt_d = issue ? issue_cnt_q + 16'd1 : issue_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      vld_q       <= '0;
      inflight_q  <= '0;
      issue_cnt_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      vld_q       <= vld_d;
      inflight_q  <= inflight_d;
      issue_cnt_q <= issue_cnt_d;
      // Idle slots carry id 0 so the output id is already clean when invalid.
      id_q[0]     <= issue ? win_id : '0;
      for (int unsigned k = 1; k < LAT; k++) begin
        id_q[k] <= id_q[k-1];
      end
    end
  end

  assign rsp_valid_o = vld_q[LAT-1];
  assign rsp_id_o    = vld_q[LAT-1] ? id_q[LAT-1] : '0;
  assign rsp_data_o  = pf_i;
  assign inflight_o  = inflight_q;
  assign issue_cnt_o = issue_cnt_q;

endmodule

// File: tb/tb_pipe_arb.sv
// Scoreboard bench for pipe_arb: a round-robin model predicts grants and tagged results,
// and a negedge monitor pops expected responses as the DUT presents them.
module tb_pipe_arb;
  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 3;
  localparam int MASK = (1 << N) - 1;

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_a, req_b, req_c, req_d;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      pa, pb, pc, pd, pf;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic [2:0]        inflight;
  logic [15:0]       issue_cnt;

  logic [N-1:0] ra [NREQ];
  logic [N-1:0] rb [NREQ];
  logic [N-1:0] rc [NREQ];
  logic [N-1:0] rd [NREQ];
  logic [N-1:0] px_q [LAT];

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   m_rr = 0;
  int   m_cnt = 0;
  bit   m_hist [LAT];
  bit   pend [NREQ];

  pipe_arb #(.N(N), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .req_i       (req),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .req_d_i     (req_d),
    .gnt_o       (gnt),
    .pa_o        (pa),
    .pb_o        (pb),
    .pc_o        (pc),
    .pd_o        (pd),
    .pf_i        (pf),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .inflight_o  (inflight),
    .issue_cnt_o (issue_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = ra[i];
      req_b[i*N +: N] = rb[i];
      req_c[i*N +: N] = rc[i];
      req_d[i*N +: N] = rd[i];
    end
  end

  // Stand-in for pipe_ex: LAT register stages, not reset, so it emits garbage after a reset.
  always @(posedge clk) begin
    px_q[0] <= ((pa + pb) + (pc - pd)) * pd;
    for (int k = 1; k < LAT; k++) begin
      px_q[k] <= px_q[k-1];
    end
  end
  assign pf = px_q[LAT-1];

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  function automatic int fmodel(input int a, input int b, input int c, input int d);
    return (((a + b) + (c - d)) * d) & MASK;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    ra[i] = N'(a);
    rb[i] = N'(b);
    rc[i] = N'(c);
    rd[i] = N'(d);
  endtask

  task automatic rand_ops(input int i);
    set_ops(i, $urandom_range(0, MASK), $urandom_range(0, MASK),
            $urandom_range(0, MASK), $urandom_range(0, MASK));
  endtask

  // Called 1ns after a rising edge; returns granted id, or -1 when nothing issued.
  task automatic step(input bit rstv, input bit env, input logic [NREQ-1:0] reqv, output int gid);
    bit              exp_iss;
    int              exp_id;
    int              idx;
    int              occ;
    logic [NREQ-1:0] exp_gnt;
    rst_n = rstv;
    en    = env;
    req   = reqv;
    if (!rstv) begin
      sbq.delete();
      m_rr  = 0;
      m_cnt = 0;
      for (int k = 0; k < LAT; k++) m_hist[k] = 1'b0;
    end
    #1;
    exp_iss = 1'b0;
    exp_id  = 0;
    if (rstv && env) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!exp_iss && reqv[idx]) begin
          exp_iss = 1'b1;
          exp_id  = idx;
        end
      end
    end
    exp_gnt = '0;
    if (exp_iss) exp_gnt[exp_id] = 1'b1;
    check("gnt", int'(gnt), int'(exp_gnt));
    check("pa", int'(pa), exp_iss ? int'(ra[exp_id]) : 0);
    check("pb", int'(pb), exp_iss ? int'(rb[exp_id]) : 0);
    check("pc", int'(pc), exp_iss ? int'(rc[exp_id]) : 0);
    check("pd", int'(pd), exp_iss ? int'(rd[exp_id]) : 0);
    if (exp_iss) begin
      sbq.push_back('{exp_id,
                      fmodel(int'(ra[exp_id]), int'(rb[exp_id]), int'(rc[exp_id]), int'(rd[exp_id])),
                      edge_cnt + LAT});
    end
    @(posedge clk);
    if (exp_iss) begin
      m_rr = (exp_id + 1) % NREQ;
      m_cnt++;
    end
    for (int k = LAT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = exp_iss;
    #1;
    occ = 0;
    for (int k = 0; k < LAT; k++) occ += int'(m_hist[k]);
    check("inflight", int'(inflight), occ);
    check("issue_cnt", int'(issue_cnt), m_cnt & 16'hFFFF);
    gid = exp_iss ? exp_id : -1;
  endtask

  // Monitor: every valid result must match the oldest outstanding issue, on its due edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n !== 1'b0 && rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d data=%0d, expected no response",
                 rsp_id, rsp_data);
      end else begin
        e = sbq.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_data", int'(rsp_data), e.data);
        check("rsp_time", edge_cnt, e.due);
      end
    end else begin
      check("rsp_valid_rst", int'(rsp_valid), rst_n === 1'b0 ? 0 : int'(rsp_valid));
      check("rsp_id_idle", int'(rsp_id), 0);
    end
  end

  initial begin
    int              gid;
    logic [NREQ-1:0] rq;
    int              exp_order [3];
    for (int i = 0; i < NREQ; i++) begin
      rand_ops(i);
      pend[i] = 1'b0;
    end
    for (int k = 0; k < LAT; k++) m_hist[k] = 1'b0;
    rst_n = 1'b1;
    en    = 1'b0;
    req   = '0;
    #1;
    // Reset held with every request up and enable high.
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_inflight", int'(inflight), 0);
    check("reset_issue_cnt", int'(issue_cnt), 0);
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 4'b1111, gid);
    step(1'b0, 1'b1, 4'b1111, gid);

    // Single op from requester 0: expected result 75.
    set_ops(0, 10, 12, 6, 3);
    step(1'b1, 1'b1, 4'b0001, gid);
    check("single_gid", gid, 0);
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 4'b0000, gid);

    // Round robin from pointer 0: grant 3 first so the pointer wraps to 0.
    step(1'b1, 1'b1, 4'b1000, gid);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < NREQ; r++) rand_ops(r);
      step(1'b1, 1'b1, 4'b1111, gid);
      check("rr_order", gid, i % NREQ);
    end
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 4'b0000, gid);

    // Skip: pointer at 2 with req=1010 grants 3, 1, 3; req1 returns 112.
    step(1'b1, 1'b1, 4'b0010, gid);
    set_ops(1, 20, 11, 1, 4);
    exp_order = '{3, 1, 3};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'b1010, gid);
      check("skip_order", gid, exp_order[i]);
    end
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 4'b0000, gid);

    // Wrapping arithmetic: 500,500,10,2 gives 992.
    set_ops(0, 500, 500, 10, 2);
    step(1'b1, 1'b1, 4'b0001, gid);
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 4'b0000, gid);

    // Three issues then enable low: results still return, no grants.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, gid);
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b1, 1'b0, 4'b1111, gid);
      check("en_low_gid", gid, -1);
    end

    // Three issues then a one-cycle reset: every tag is discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, gid);
    step(1'b0, 1'b1, 4'b1111, gid);
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, 4'b0000, gid);
    check("post_reset_inflight", int'(inflight), 0);

    // Random traffic: requests held until granted, occasional drops, random enable.
    for (int c = 0; c < 3000; c++) begin
      rq = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          rand_ops(i);
        end else if (pend[i] && ($urandom_range(0, 19) == 0)) begin
          pend[i] = 1'b0;
        end
        rq[i] = pend[i];
      end
      step(1'b1, ($urandom_range(0, 4) != 0), rq, gid);
      if (gid >= 0) pend[gid] = 1'b0;
    end
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, 4'b0000, gid);
    check("drain_empty", sbq.size(), 0);

    // Issue counter wraps to 0 after 65536 issues from reset.
    step(1'b0, 1'b1, 4'b0000, gid);
    rand_ops(0);
    for (int i = 0; i < 65536; i++) step(1'b1, 1'b1, 4'b0001, gid);
    check("issue_cnt_wrap", int'(issue_cnt), 0);
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b1, 4'b0000, gid);
    check("final_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
